char_writer: RTL and testbench
==============================

CHAR_WRITER -- requirements
Module: char_writer

Interface
REQ-001 SHALL have parameter ROWS, default 24, number of text rows on screen.
REQ-002 SHALL have parameter COLS, default 80, characters per row.
REQ-003 SHALL have parameter ROW_BITS, default 5, width of cursor_y.
REQ-004 SHALL have parameter COL_BITS, default 7, width of cursor_x.
REQ-005 SHALL have parameter ADDR_BITS, default 11, width of char buffer addresses.
REQ-006 SHALL have parameter BUF_SIZE, default ROWS*COLS (1920), circular char buffer length.
REQ-007 SHALL have port clk  input  1  clock, all logic on rising edge.
REQ-008 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-009 SHALL have ports char_in (input, 8, byte to display), char_valid (input, 1, byte present) and char_ready (output, 1, byte accepted when char_valid and char_ready are both high at a rising edge).
REQ-010 SHALL have ports cursor_x (output, COL_BITS, column 0..COLS-1) and cursor_y (output, ROW_BITS, row 0..ROWS-1), feeding the video generator.
REQ-011 SHALL have port first_char  output  ADDR_BITS  buffer address of the top-left visible char, feeding the video generator.
REQ-012 SHALL have ports wr_en (output, 1), wr_addr (output, ADDR_BITS) and wr_data (output, 8), a char buffer write port; the buffer takes one write per cycle.

Function
REQ-013 SHALL keep all outputs registered.
REQ-014 SHALL implement FSM states CLEAR_ALL, IDLE and CLEAR_LINE; char_ready SHALL be 1 only in IDLE.
REQ-015 SHALL keep an internal cur_addr equal to (first_char + cursor_y*COLS + cursor_x) mod BUF_SIZE, updated incrementally with no multiplier.
REQ-016 SHALL do all address arithmetic modulo BUF_SIZE (BUF_SIZE-1 + 1 -> 0; 0 - 1 -> BUF_SIZE-1).
REQ-017 SHALL, in CLEAR_ALL, write 0x20 to addresses 0..BUF_SIZE-1, one per cycle in ascending order, then enter IDLE.
REQ-018 SHALL, for an accepted printable byte (0x20..0x7E), present wr_en=1, wr_addr=cur_addr and wr_data=char_in in the cycle after acceptance.
REQ-019 SHALL, after a printable byte, increment cursor_x and cur_addr if cursor_x<COLS-1; at cursor_x=COLS-1 the cursor SHALL stay put (no auto-wrap) and later printables SHALL overwrite that cell.
REQ-020 SHALL, on CR (0x0D), set cursor_x=0 and cur_addr=cur_addr-cursor_x; no write.
REQ-021 SHALL, on BS (0x08), decrement cursor_x and cur_addr if cursor_x>0, else do nothing; no write.
REQ-022 SHALL, on LF (0x0A) with cursor_y<ROWS-1, increment cursor_y and set cur_addr+=COLS; no write.
REQ-023 SHALL, on LF with cursor_y=ROWS-1, scroll: first_char+=COLS, cur_addr+=COLS, cursor_y unchanged, state -> CLEAR_LINE.
REQ-024 SHALL, in CLEAR_LINE, write 0x20 to the COLS addresses starting at the pre-scroll first_char (the new bottom row), ascending with wrap, one per cycle starting the cycle after LF acceptance, then return to IDLE.
REQ-025 SHALL ignore all other bytes: consume them with no state, cursor or write change.
REQ-026 SHALL hold wr_en=0 in every cycle without a scheduled write.
REQ-027 SHALL raise char_ready in the cycle after the last clear write is presented; char_ready SHALL be 0 from the cycle after a scrolling LF is accepted.
REQ-028 SHALL accept back-to-back bytes at one per cycle in IDLE.

Reset
REQ-029 SHALL, while reset is high, force cursor_x=0, cursor_y=0, first_char=0, cur_addr=0, wr_en=0, wr_addr=0, wr_data=0, char_ready=0 and state=CLEAR_ALL with clear counter 0.
REQ-030 SHALL, on reset during any state, including mid-clear, abandon the operation and restart the full clear from address 0 after reset falls.
REQ-031 SHALL present the first clear write (addr 0) in the first cycle after reset deasserts.

Verification
REQ-032 SHALL test power-on: release reset -> writes 0x20 to addr 0..1919 on cycles 1..1920, char_ready=1 at cycle 1921, cursor (0,0), first_char=0.
REQ-033 SHALL test text: send "AB" back-to-back -> writes (0,0x41),(1,0x42) on consecutive cycles, cursor_x=2; then CR -> cursor_x=0, no write.
REQ-034 SHALL test the right margin: 82 printables on row 0 -> last three writes all at addr 79, cursor_x=79; BS at x=0 -> no change.
REQ-035 SHALL test scroll: 23 LFs -> cursor_y=23, no stall; 24th LF -> first_char=80, char_ready low for 80 cycles, writes 0x20 to addr 0..79; next 'X' at x=0 writes addr 0.
REQ-036 SHALL test wrap: 24 scrolls -> first_char returns 0 after 1840; the 24th clear writes addr 1840..1919; BS from x=0 after CR makes no write.
REQ-037 SHALL test reset mid-clear: assert reset at CLEAR_LINE write 40 -> after release, full clear restarts at addr 0, first_char=0, cursor (0,0).

Source files
------------

// File: rtl/char_writer_if.sv
// Character writer bus bundle.
// Groups the byte-stream handshake (char_in/char_valid/char_ready), the
// cursor/scroll outputs for the video generator (cursor_x, cursor_y,
// first_char) and the char-buffer write port (wr_en, wr_addr, wr_data).
// master: byte source / observer side.  slave: the char_writer itself.
interface char_writer_if #(
  parameter int unsigned ROW_BITS  = 5,
  parameter int unsigned COL_BITS  = 7,
  parameter int unsigned ADDR_BITS = 11
);
  logic [7:0]           char_in;
  logic                 char_valid;
  logic                 char_ready;
  logic [COL_BITS-1:0]  cursor_x;
  logic [ROW_BITS-1:0]  cursor_y;
  logic [ADDR_BITS-1:0] first_char;
  logic                 wr_en;
  logic [ADDR_BITS-1:0] wr_addr;
  logic [7:0]           wr_data;

  modport master (
    output char_in, char_valid,
    input  char_ready, cursor_x, cursor_y, first_char, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  char_in, char_valid,
    output char_ready, cursor_x, cursor_y, first_char, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/char_writer.sv
// Text-mode character writer.
// Consumes a byte stream, tracks the cursor and scroll origin of a circular
// ROWS x COLS character buffer, and issues one buffer write per cycle.
// Ports:
//   clk   - clock, rising edge
//   reset - synchronous, active-high
//   bus   - char_writer_if.slave: byte handshake in, cursor/first_char and
//           buffer write port out (all registered)
module char_writer #(
  parameter int unsigned ROWS      = 24,
  parameter int unsigned COLS      = 80,
  parameter int unsigned ROW_BITS  = 5,
  parameter int unsigned COL_BITS  = 7,
  parameter int unsigned ADDR_BITS = 11,
  parameter int unsigned BUF_SIZE  = ROWS * COLS
) (
  input  logic          clk,
  input  logic          reset,
  char_writer_if.slave  bus
);

  localparam int unsigned AW1 = ADDR_BITS + 1;

  localparam logic [AW1-1:0]       BUF_W     = AW1'(BUF_SIZE);
  localparam logic [ADDR_BITS-1:0] ONE_A     = ADDR_BITS'(1);
  localparam logic [ADDR_BITS-1:0] COLS_A    = ADDR_BITS'(COLS);
  localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(BUF_SIZE - 1);
  localparam logic [COL_BITS-1:0]  LAST_COL  = COL_BITS'(COLS - 1);
  localparam logic [ROW_BITS-1:0]  LAST_ROW  = ROW_BITS'(ROWS - 1);
  localparam logic [7:0]           SPACE     = 8'h20;

  typedef enum logic [1:0] {CLEAR_ALL, IDLE, CLEAR_LINE} state_e;

  state_e               state_q;
  logic [COL_BITS-1:0]  cursor_x_q;
  logic [ROW_BITS-1:0]  cursor_y_q;
  logic [ADDR_BITS-1:0] first_char_q;
  logic [ADDR_BITS-1:0] cur_addr_q;
  logic [ADDR_BITS-1:0] clr_addr_q;
  logic [COL_BITS-1:0]  clr_cnt_q;
  logic                 char_ready_q;
  logic                 wr_en_q;
  logic [ADDR_BITS-1:0] wr_addr_q;
  logic [7:0]           wr_data_q;

  // (a + b) mod BUF_SIZE, both operands already below BUF_SIZE
  function automatic logic [ADDR_BITS-1:0] add_mod(input logic [ADDR_BITS-1:0] a,
                                                   input logic [ADDR_BITS-1:0] b);
    logic [AW1-1:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= BUF_W) s = s - BUF_W;
    return s[ADDR_BITS-1:0];
  endfunction

  // (a - b) mod BUF_SIZE, both operands already below BUF_SIZE
  function automatic logic [ADDR_BITS-1:0] sub_mod(input logic [ADDR_BITS-1:0] a,
                                                   input logic [ADDR_BITS-1:0] b);
    logic [AW1-1:0] s;
    if (a >= b) s = {1'b0, a} - {1'b0, b};
    else        s = {1'b0, a} + BUF_W - {1'b0, b};
    return s[ADDR_BITS-1:0];
  endfunction

  logic       acc;
  logic [7:0] ch;
  assign acc = char_ready_q & bus.char_valid;
  assign ch  = bus.char_in;

  // Control FSM, cursor tracking and write port
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= CLEAR_ALL;
      cursor_x_q   <= '0;
      cursor_y_q   <= '0;
      first_char_q <= '0;
      cur_addr_q   <= '0;
      clr_addr_q   <= '0;
      clr_cnt_q    <= '0;
      char_ready_q <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
    end else begin
      wr_en_q <= 1'b0;
      case (state_q)
        CLEAR_ALL: begin
          // Linear sweep 0..BUF_SIZE-1, never wraps
          wr_en_q    <= 1'b1;
          wr_addr_q  <= clr_addr_q;
          wr_data_q  <= SPACE;
          clr_addr_q <= clr_addr_q + ONE_A;
          if (clr_addr_q == LAST_ADDR) state_q <= IDLE;
        end
        CLEAR_LINE: begin
          wr_en_q    <= 1'b1;
          wr_addr_q  <= clr_addr_q;
          wr_data_q  <= SPACE;
          clr_addr_q <= add_mod(clr_addr_q, ONE_A);
          clr_cnt_q  <= clr_cnt_q + COL_BITS'(1);
          if (clr_cnt_q == LAST_COL) state_q <= IDLE;
        end
        IDLE: begin
          // Ready comes up one cycle after entering IDLE from a clear
          char_ready_q <= 1'b1;
          if (acc) begin
            if (ch >= 8'h20 && ch <= 8'h7E) begin
              wr_en_q   <= 1'b1;
              wr_addr_q <= cur_addr_q;
              wr_data_q <= ch;
              if (cursor_x_q != LAST_COL) begin
                cursor_x_q <= cursor_x_q + COL_BITS'(1);
                cur_addr_q <= add_mod(cur_addr_q, ONE_A);
              end
            end else if (ch == 8'h0D) begin
              cursor_x_q <= '0;
              cur_addr_q <= sub_mod(cur_addr_q, ADDR_BITS'(cursor_x_q));
            end else if (ch == 8'h08) begin
              if (cursor_x_q != '0) begin
                cursor_x_q <= cursor_x_q - COL_BITS'(1);
                cur_addr_q <= sub_mod(cur_addr_q, ONE_A);
              end
            end else if (ch == 8'h0A) begin
              cur_addr_q <= add_mod(cur_addr_q, COLS_A);
              if (cursor_y_q != LAST_ROW) begin
                cursor_y_q <= cursor_y_q + ROW_BITS'(1);
              end else begin
                // Scroll: old top row becomes the new bottom row; its first
                // blanking write goes out right away, the rest in CLEAR_LINE
                first_char_q <= add_mod(first_char_q, COLS_A);
                wr_en_q      <= 1'b1;
                wr_addr_q    <= first_char_q;
                wr_data_q    <= SPACE;
                clr_addr_q   <= add_mod(first_char_q, ONE_A);
                clr_cnt_q    <= COL_BITS'(1);
                char_ready_q <= 1'b0;
                state_q      <= CLEAR_LINE;
              end
            end
          end
        end
        default: state_q <= CLEAR_ALL;
      endcase
    end
  end

  assign bus.char_ready = char_ready_q;
  assign bus.cursor_x   = cursor_x_q;
  assign bus.cursor_y   = cursor_y_q;
  assign bus.first_char = first_char_q;
  assign bus.wr_en      = wr_en_q;
  assign bus.wr_addr    = wr_addr_q;
  assign bus.wr_data    = wr_data_q;

endmodule

// File: tb/tb_char_writer.sv
// Self-checking bench for char_writer: directed scenarios plus randomized
// byte streams, compared cycle by cycle against a screen-level model.
module tb_char_writer;

  localparam int unsigned ROWS = 24;
  localparam int unsigned COLS = 80;
  localparam int unsigned BUF  = ROWS * COLS;
  localparam int unsigned LIM  = 3000;

  logic clk = 1'b0;
  logic reset = 1'b1;

  char_writer_if #(.ROW_BITS(5), .COL_BITS(7), .ADDR_BITS(11)) bus ();

  char_writer #(.ROWS(ROWS), .COLS(COLS), .ROW_BITS(5), .COL_BITS(7),
                .ADDR_BITS(11), .BUF_SIZE(BUF)) dut (
    .clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    int unsigned cyc;
    int unsigned addr;
    int unsigned data;
  } wr_t;

  wr_t         exp_q[$];
  wr_t         e;
  int unsigned cyc = 0;
  logic        rst_prev = 1'b1;
  int unsigned ready_at = 32'hFFFF_FFFF;
  int unsigned mx = 0, my = 0, mfirst = 0;
  int unsigned last_wait = 0;
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h exp %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(posedge clk) begin
    rst_prev <= reset;
    cyc      <= cyc + 1;
  end

  // Per-cycle monitor: reset values, ready timing and the exact write schedule
  always @(negedge clk) begin
    if (rst_prev) begin
      check_eq("rst_wr_en", 32'(bus.wr_en), 0);
      check_eq("rst_ready", 32'(bus.char_ready), 0);
      check_eq("rst_cursor", {bus.cursor_y, bus.cursor_x}, 0);
      check_eq("rst_first", 32'(bus.first_char), 0);
      check_eq("rst_wr_bus", {bus.wr_addr, bus.wr_data}, 0);
    end else begin
      check_eq("ready", 32'(bus.char_ready), (cyc >= ready_at) ? 1 : 0);
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        e = exp_q.pop_front();
        check_eq("wr_en", 32'(bus.wr_en), 1);
        check_eq("wr_addr", 32'(bus.wr_addr), e.addr);
        check_eq("wr_data", 32'(bus.wr_data), e.data);
      end else begin
        check_eq("wr_en_quiet", 32'(bus.wr_en), 0);
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Screen-level reference: what a byte accepted at edge k does
  task automatic model_accept(input logic [7:0] b, input int unsigned k);
    if (b >= 8'h20 && b <= 8'h7E) begin
      exp_q.push_back('{k, (mfirst + my * COLS + mx) % BUF, 32'(b)});
      if (mx < COLS - 1) mx++;
    end else if (b == 8'h0D) begin
      mx = 0;
    end else if (b == 8'h08) begin
      if (mx > 0) mx--;
    end else if (b == 8'h0A) begin
      if (my < ROWS - 1) my++;
      else begin
        for (int i = 0; i < int'(COLS); i++)
          exp_q.push_back('{k + 32'(i), (mfirst + 32'(i)) % BUF, 32'h20});
        mfirst    = (mfirst + COLS) % BUF;
        ready_at  = k + COLS;
      end
    end
  endtask

  task automatic check_state();
    check_eq("cursor_x", 32'(bus.cursor_x), mx);
    check_eq("cursor_y", 32'(bus.cursor_y), my);
    check_eq("first_char", 32'(bus.first_char), mfirst);
  endtask

  task automatic send(input logic [7:0] b);
    int unsigned n;
    n = 0;
    bus.char_in    = b;
    bus.char_valid = 1'b1;
    while (!bus.char_ready && n < LIM) begin
      step();
      n++;
    end
    last_wait = n;
    if (!bus.char_ready) begin
      check_eq("send_ready_timeout", 32'(bus.char_ready), 1);
      bus.char_valid = 1'b0;
      return;
    end
    model_accept(b, cyc + 1);
    step();
    bus.char_valid = 1'b0;
    check_state();
  endtask

  task automatic idle(input int unsigned n);
    bus.char_valid = 1'b0;
    repeat (n) step();
  endtask

  task automatic wait_ready();
    int unsigned n;
    n = 0;
    while (!bus.char_ready && n < LIM) begin
      step();
      n++;
    end
    check_eq("wait_ready", 32'(bus.char_ready), 1);
  endtask

  task automatic do_reset(input int unsigned n);
    reset = 1'b1;
    bus.char_valid = 1'b0;
    exp_q.delete();
    ready_at = 32'hFFFF_FFFF;
    mx = 0; my = 0; mfirst = 0;
    repeat (n) step();
    reset = 1'b0;
    for (int i = 0; i < int'(BUF); i++)
      exp_q.push_back('{cyc + 1 + 32'(i), 32'(i), 32'h20});
    ready_at = cyc + 1 + BUF;
  endtask

  function automatic logic [7:0] rand_byte();
    int unsigned r;
    logic [7:0]  o;
    r = $urandom_range(0, 99);
    if (r < 60)      return 8'($urandom_range(8'h20, 8'h7E));
    else if (r < 70) return 8'h0D;
    else if (r < 82) return 8'h0A;
    else if (r < 90) return 8'h08;
    o = 8'($urandom_range(0, 255));
    if ((o >= 8'h20 && o <= 8'h7E) || o == 8'h0D || o == 8'h0A || o == 8'h08) o = 8'h1B;
    return o;
  endfunction

  initial begin
    int unsigned stalls;
    int unsigned n;
    bus.char_in    = 8'h00;
    bus.char_valid = 1'b0;

    // Power-on clear
    do_reset(3);
    wait_ready();
    check_eq("po_ready_cycle", cyc, ready_at);
    check_eq("po_cursor", {bus.cursor_y, bus.cursor_x}, 0);
    check_eq("po_first", 32'(bus.first_char), 0);

    // "AB" back-to-back, then CR
    send(8'h41);
    send(8'h42);
    check_eq("ab_x", 32'(bus.cursor_x), 2);
    send(8'h0D);
    check_eq("cr_x", 32'(bus.cursor_x), 0);

    // Right margin: 82 printables, then CR and BS at column 0
    for (int i = 0; i < 82; i++) send(8'($urandom_range(8'h21, 8'h7E)));
    check_eq("margin_x", 32'(bus.cursor_x), 79);
    send(8'h0D);
    send(8'h08);
    check_eq("bs_x0", 32'(bus.cursor_x), 0);

    // 23 line feeds without stall, then a scrolling one
    stalls = 0;
    for (int i = 0; i < 23; i++) begin
      send(8'h0A);
      stalls += last_wait;
    end
    check_eq("lf_no_stall", stalls, 0);
    check_eq("lf_y", 32'(bus.cursor_y), 23);
    send(8'h0A);
    check_eq("scroll_first", 32'(bus.first_char), 80);
    check_eq("scroll_ready_low", 32'(bus.char_ready), 0);
    n = 0;
    while (!bus.char_ready && n < 200) begin
      step();
      n++;
    end
    check_eq("scroll_busy_cycles", n, 80);
    send(8'h58);

    // Wrap of first_char after 24 scrolls in total
    for (int i = 2; i <= 24; i++) begin
      send(8'h0A);
      if (i == 23) check_eq("wrap_first_1840", 32'(bus.first_char), 1840);
    end
    check_eq("wrap_first_0", 32'(bus.first_char), 0);
    wait_ready();
    send(8'h0D);
    send(8'h08);
    check_eq("wrap_bs_x", 32'(bus.cursor_x), 0);

    // Reset in the middle of a line clear
    send(8'h0A);
    repeat (39) step();
    do_reset(2);
    wait_ready();
    check_eq("mid_rst_first", 32'(bus.first_char), 0);
    check_eq("mid_rst_cursor", {bus.cursor_y, bus.cursor_x}, 0);

    // Randomized byte stream with random gaps
    for (int i = 0; i < 600; i++) begin
      send(rand_byte());
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end

    idle(100);
    check_eq("pending_writes", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
